lut_rr_arbiter: RTL and testbench
=================================

Name: lut_rr_arbiter

Overview:
- Shares the single Ziggurat LUT ROM (rmost_coord / wedge_bound_ratio, 1-cycle registered read) between NREQ GRNG sampling lanes.
- Round-robin arbitration over valid/ready request ports, one ROM lookup issued per cycle.
- Returns each lookup result to the issuing lane, tagged by a one-hot response strobe.
- Sits between the per-lane rectangle-index generators and the LUT ROM instance inside the grng core.

Parameters:
NREQ, 4, number of requesting lanes (2..16, need not be a power of two)
LOG2NREQ, 2, width of lane index (ceil(log2(NREQ)))
N, 256, number of Ziggurat rectangles (ROM depth)
LOG2N, 8, width of rectangle index

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-lane lookup request valid
req_idx  input  NREQ*LOG2N  per-lane rectangle index, lane k at bits [k*LOG2N +: LOG2N]
req_ready  output  NREQ  one-hot grant; handshake when req_valid[k] & req_ready[k]
lut_idx  output  LOG2N  rectangle index driven to the ROM
lut_rmost_coord  input  18  ROM data, signed Q3.14, valid 1 cycle after lut_idx sampled
lut_wedge_bound_ratio  input  32  ROM data, UQ4.28, same timing
rsp_valid  output  NREQ  one-hot response strobe, 1 cycle wide
rsp_rmost_coord  output  18  signed Q3.14 result for the strobed lane
rsp_wedge_bound_ratio  output  32  UQ4.28 result for the strobed lane

Behaviour:
- Reset (rst_n low, asynchronous): rr_ptr=0, all pipeline valids=0, lut_idx=0, rsp_valid=0, rsp_rmost_coord=0, rsp_wedge_bound_ratio=0. req_ready is combinational and is therefore 0 while no request is valid.
- Arbitration (combinational, cycle T):
  - Search lanes starting at rr_ptr, ascending, wrapping at NREQ-1 to 0. The first lane with req_valid=1 wins.
  - req_ready is one-hot for the winner, otherwise all zero.
  - req_ready never asserts for a lane whose req_valid=0.
  - Lanes may change req_idx while not granted. req_valid must hold until granted (AXI-style).
- On an accepted grant at edge end of T:
  - lut_idx <= winner's req_idx.
  - s1_valid <= 1, s1_lane <= winner.
  - rr_ptr <= (winner+1) wrapped at NREQ, not power-of-2 masked.
- No grant: s1_valid <= 0, and lut_idx holds its last value, so the ROM address stays stable and does not toggle.
- Stage 2:
  - The ROM registers data at edge end of T+1.
  - At edge end of T+2, the arbiter captures: rsp_valid <= s2_valid ? onehot(s2_lane) : 0, and the data registers <= ROM outputs.
  - Data registers update only when s2_valid=1 and otherwise hold.
- Latency: handshake at T produces rsp_valid at T+3 (visible during the cycle after edge T+2). This is fixed and independent of load.
- Throughput: 1 lookup/cycle aggregate. With all lanes valid, each lane gets exactly 1 grant per NREQ cycles.
- No response backpressure: lanes must always accept rsp_valid.
- Responses are delivered in grant order. The same lane may have up to 3 lookups in flight.
- Boundaries:
  - Single lane continuously valid: granted every cycle. rr_ptr still advances to winner+1, and the search wraps back to that lane.
  - winner = NREQ-1: rr_ptr wraps to 0.
  - Request deasserted in the same cycle a different lane becomes valid: only that cycle's req_valid is considered.
  - rst_n asserted mid-operation: in-flight lookups are discarded with no rsp_valid, even if ROM data arrives afterwards. The first post-reset grant goes to the lowest valid lane.
- Arithmetic: data is passed through unmodified. Sign and format are preserved. No width conversion.

Decomposition:
- Package grng_lut_pkg: RMOST_W=18, RMOST_FRAC=14, WBR_W=32, WBR_FRAC=28, default N/LOG2N, function clog2.
- Shared with the existing ROM and with the wedge-test datapath.
- One sub-module, rr_arbiter (NREQ, LOG2NREQ):
  - Inputs: valid vector, rr_ptr.
  - Outputs: one-hot grant, binary winner, any_grant.
  - Purely combinational. rr_ptr state lives in lut_rr_arbiter.
- Everything else (pipeline tags, response registers) stays in the top module.

Test Plan:
- Bench ROM stub: rmost[i]=i*3, wbr[i]=i<<20, 1-cycle registered.
- Lane 2 only, idx=0x05 at cycle 10 → req_ready=4'b0100 at 10; lut_idx=0x05 after edge 10; rsp_valid=4'b0100 at cycle 13 with rmost=15, wbr=0x00500000, high for exactly 1 cycle.
- All 4 lanes valid continuously, idx_k=k+1, from rr_ptr=0 → grants 0,1,2,3,0,1…; rsp_valid shows the same order 3 cycles later; 8 responses in 8 cycles.
- Lanes 1 and 3 valid, rr_ptr=2 → lane 3 granted first, then lane 1; rr_ptr ends at 2.
- NREQ=3 build, all lanes valid → grant sequence 0,1,2,0 (no phantom lane 3); rr_ptr never reaches 3.
- Idx 0xFF granted, then 2 idle cycles → lut_idx holds 0xFF; response rmost=765 (0x2FD), wbr=0x0FF00000; rsp_valid=0 during the idle response slots.
- Grant at cycle 20, rst_n low at cycle 21 for 1 cycle → no rsp_valid ever appears for that request; all outputs 0 during reset; first grant after release goes to lane 0 when lanes 0 and 2 are valid.

Source files
------------

// File: rtl/grng_lut_pkg.sv
// ---------------------------------------------------------------------------
// grng_lut_pkg
// Shared definitions for the Ziggurat LUT path of the GRNG core: fixed-point
// formats of the two ROM words, default ROM geometry and an elaboration-time
// clog2 helper. Used by the LUT ROM, the LUT arbiter and the wedge-test
// datapath so that all of them agree on widths.
// ---------------------------------------------------------------------------
package grng_lut_pkg;

  // rmost_coord: signed Q3.14
  localparam int RMOST_W    = 18;
  localparam int RMOST_FRAC = 14;

  // wedge_bound_ratio: unsigned UQ4.28
  localparam int WBR_W      = 32;
  localparam int WBR_FRAC   = 28;

  // Default ROM geometry (number of Ziggurat rectangles and index width)
  localparam int DEF_N      = 256;
  localparam int DEF_LOG2N  = 8;

  typedef logic signed [RMOST_W-1:0] rmost_t;
  typedef logic        [WBR_W-1:0]   wbr_t;

  // ceil(log2(value)) for value >= 1; intended for constant expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. The search starts at rr_ptr_i and
// walks upward, wrapping from NREQ-1 to 0; the first asserted valid wins.
// The pointer register itself lives in the parent.
//
// Ports
//   valid_i      [NREQ]      request vector
//   rr_ptr_i     [LOG2NREQ]  highest-priority lane this cycle (< NREQ)
//   grant_o      [NREQ]      one-hot grant, all zero when nothing is valid
//   winner_o     [LOG2NREQ]  binary index of the granted lane
//   any_grant_o              a grant is being issued
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ     = 4,
  parameter int LOG2NREQ = 2
) (
  input  logic [NREQ-1:0]     valid_i,
  input  logic [LOG2NREQ-1:0] rr_ptr_i,
  output logic [NREQ-1:0]     grant_o,
  output logic [LOG2NREQ-1:0] winner_o,
  output logic                any_grant_o
);

  int                  lane;
  logic [LOG2NREQ-1:0] lane_idx;

  // NOTE: every output gets a default before the search loop, otherwise the
  // conditional assignments below would infer latches.
  always_comb begin
    grant_o     = '0;
    winner_o    = '0;
    any_grant_o = 1'b0;
    lane        = 0;
    lane_idx    = '0;
    for (int off = 0; off < NREQ; off++) begin
      // Wrap by subtraction rather than masking: NREQ need not be a power
      // of two. Two steps keep the index in range even for an illegal
      // pointer value, so the select below can never run off the vector.
      lane = int'(rr_ptr_i) + off;
      if (lane >= NREQ) lane = lane - NREQ;
      if (lane >= NREQ) lane = lane - NREQ;
      lane_idx = LOG2NREQ'(lane);
      if (!any_grant_o && valid_i[lane_idx]) begin
        any_grant_o        = 1'b1;
        grant_o[lane_idx]  = 1'b1;
        winner_o           = lane_idx;
      end
    end
  end

endmodule

// File: rtl/lut_rr_arbiter.sv
// ---------------------------------------------------------------------------
// lut_rr_arbiter
// Shares one Ziggurat LUT ROM (1-cycle registered read) between NREQ GRNG
// lanes. One lookup is issued per cycle in round-robin order; each result is
// returned to its lane with a one-hot strobe a fixed 3 cycles after the
// handshake. There is no response backpressure.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   req_valid   [NREQ]       per-lane lookup request
//   req_idx     [NREQ*LOG2N] per-lane rectangle index, lane k at k*LOG2N
//   req_ready   [NREQ]       one-hot grant (combinational)
//   lut_idx     [LOG2N]      ROM address, holds its value when idle
//   lut_rmost_coord          ROM data, signed Q3.14, one cycle after lut_idx
//   lut_wedge_bound_ratio    ROM data, UQ4.28, same timing
//   rsp_valid   [NREQ]       one-hot response strobe, one cycle wide
//   rsp_rmost_coord          result for the strobed lane
//   rsp_wedge_bound_ratio    result for the strobed lane
//
// Pipeline: grant at edge T loads lut_idx and the s1 tag; the ROM registers
// its data at T+1 while the tag moves to s2; at T+2 the tag becomes the
// response strobe and the ROM data is captured next to it.
// ---------------------------------------------------------------------------
module lut_rr_arbiter
  import grng_lut_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int LOG2NREQ = 2,
  parameter int N        = DEF_N,
  parameter int LOG2N    = DEF_LOG2N
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*LOG2N-1:0] req_idx,
  output logic [NREQ-1:0]       req_ready,
  output logic [LOG2N-1:0]      lut_idx,
  input  rmost_t                lut_rmost_coord,
  input  wbr_t                  lut_wedge_bound_ratio,
  output logic [NREQ-1:0]       rsp_valid,
  output rmost_t                rsp_rmost_coord,
  output wbr_t                  rsp_wedge_bound_ratio
);

  // Reject inconsistent parameter sets at elaboration.
  if (NREQ < 2 || LOG2NREQ != clog2(NREQ)) begin : g_bad_nreq
    $error("lut_rr_arbiter: LOG2NREQ must equal clog2(NREQ), NREQ >= 2");
  end
  if (N < 2 || LOG2N != clog2(N)) begin : g_bad_n
    $error("lut_rr_arbiter: LOG2N must equal clog2(N), N >= 2");
  end

  // Arbitration
  logic [LOG2NREQ-1:0] rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]     grant;
  logic [LOG2NREQ-1:0] winner;
  logic                any_grant;

  rr_arbiter #(
    .NREQ     (NREQ),
    .LOG2NREQ (LOG2NREQ)
  ) u_rr_arbiter (
    .valid_i     (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (grant),
    .winner_o    (winner),
    .any_grant_o (any_grant)
  );

  assign req_ready = grant;

  // Pipeline tags and response registers
  logic [LOG2N-1:0]    lut_idx_q, lut_idx_d;
  logic                s1_valid_q;
  logic [LOG2NREQ-1:0] s1_lane_q;
  logic                s2_valid_q;
  logic [LOG2NREQ-1:0] s2_lane_q;
  logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
  rmost_t              rsp_rmost_q;
  wbr_t                rsp_wbr_q;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    lut_idx_d   = lut_idx_q;  // idle cycles keep the ROM address stable
    rsp_valid_d = '0;
    if (any_grant) begin
      lut_idx_d = req_idx[int'(winner)*LOG2N +: LOG2N];
      rr_ptr_d  = (winner == LOG2NREQ'(NREQ - 1)) ? '0 : winner + 1'b1;
    end
    if (s2_valid_q) begin
      rsp_valid_d = NREQ'(1) << s2_lane_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so that every
  // register samples the values from before the edge, regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Clearing the tags drops in-flight lookups; ROM data arriving after
      // reset is never strobed out.
      rr_ptr_q    <= '0;
      lut_idx_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_lane_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_lane_q   <= '0;
      rsp_valid_q <= '0;
      rsp_rmost_q <= '0;
      rsp_wbr_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      lut_idx_q   <= lut_idx_d;
      s1_valid_q  <= any_grant;
      s1_lane_q   <= winner;
      s2_valid_q  <= s1_valid_q;
      s2_lane_q   <= s1_lane_q;
      rsp_valid_q <= rsp_valid_d;
      if (s2_valid_q) begin
        rsp_rmost_q <= lut_rmost_coord;
        rsp_wbr_q   <= lut_wedge_bound_ratio;
      end
    end
  end

  assign lut_idx               = lut_idx_q;
  assign rsp_valid             = rsp_valid_q;
  assign rsp_rmost_coord       = rsp_rmost_q;
  assign rsp_wedge_bound_ratio = rsp_wbr_q;

endmodule

// File: tb/tb_lut_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lut_rr_arbiter
// Directed bench for lut_rr_arbiter (NREQ=4) plus a second NREQ=3 instance
// for the non-power-of-two wrap. Inputs change on the falling edge; the
// grant is compared 1 time unit later. Each expected grant pushes its
// expected response (lane, ROM data, cycle) into a scoreboard queue that a
// separate monitor drains whenever rsp_valid is seen.
// ROM stub: rmost[i] = i*3, wbr[i] = i<<20, one-cycle registered.
// ---------------------------------------------------------------------------
module tb_lut_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // NREQ = 4 instance
  logic [3:0]  req_valid;
  logic [31:0] req_idx;
  logic [3:0]  req_ready;
  logic [7:0]  lut_idx;
  logic [17:0] rom_rmost;
  logic [31:0] rom_wbr;
  logic [3:0]  rsp_valid;
  logic [17:0] rsp_rmost;
  logic [31:0] rsp_wbr;

  lut_rr_arbiter #(.NREQ(4), .LOG2NREQ(2), .N(256), .LOG2N(8)) u_dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .req_valid             (req_valid),
    .req_idx               (req_idx),
    .req_ready             (req_ready),
    .lut_idx               (lut_idx),
    .lut_rmost_coord       (rom_rmost),
    .lut_wedge_bound_ratio (rom_wbr),
    .rsp_valid             (rsp_valid),
    .rsp_rmost_coord       (rsp_rmost),
    .rsp_wedge_bound_ratio (rsp_wbr)
  );

  always @(posedge clk) begin
    rom_rmost <= 18'(lut_idx) * 18'd3;
    rom_wbr   <= 32'(lut_idx) << 20;
  end

  // NREQ = 3 instance (grant order only)
  logic [2:0]  req_valid3;
  logic [23:0] req_idx3;
  logic [2:0]  req_ready3;
  logic [7:0]  lut_idx3;
  logic [2:0]  rsp_valid3;
  logic [17:0] rsp_rmost3;
  logic [31:0] rsp_wbr3;

  lut_rr_arbiter #(.NREQ(3), .LOG2NREQ(2), .N(256), .LOG2N(8)) u_dut3 (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .req_valid             (req_valid3),
    .req_idx               (req_idx3),
    .req_ready             (req_ready3),
    .lut_idx               (lut_idx3),
    .lut_rmost_coord       (18'd0),
    .lut_wedge_bound_ratio (32'd0),
    .rsp_valid             (rsp_valid3),
    .rsp_rmost_coord       (rsp_rmost3),
    .rsp_wedge_bound_ratio (rsp_wbr3)
  );

  // Bookkeeping
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  lane;
    logic [17:0] rmost;
    logic [31:0] wbr;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus: drive after the falling edge, check the grant,
  // and queue the expected response for a granted lookup.
  task automatic drive(input logic [3:0] v, input logic [31:0] idx,
                       input logic [3:0] exp_ready, input bit push,
                       input string name);
    exp_t       e;
    logic [7:0] li;
    @(negedge clk);
    req_valid = v;
    req_idx   = idx;
    #1;
    check(name, 64'(req_ready), 64'(exp_ready));
    if (push && exp_ready != 4'b0000) begin
      li = 8'h00;
      for (int k = 0; k < 4; k++) if (exp_ready[k]) li = idx[k*8 +: 8];
      e.lane  = exp_ready;
      e.rmost = 18'(li) * 18'd3;
      e.wbr   = 32'(li) << 20;
      e.cyc   = cyc + 3;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(4'b0000, 32'h0, 4'b0000, 1'b0, "idle_ready");
  endtask

  // Monitor: any strobe must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (sb.size() > 0 && cyc > sb[0].cyc) begin
      mon_e = sb.pop_front();
      check("rsp_missing", 64'(cyc), 64'(mon_e.cyc));
    end
    if (rsp_valid != 4'b0000) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_lane",  64'(rsp_valid), 64'(mon_e.lane));
        check("rsp_rmost", 64'(rsp_rmost), 64'(mon_e.rmost));
        check("rsp_wbr",   64'(rsp_wbr),   64'(mon_e.wbr));
        check("rsp_cycle", 64'(cyc),       64'(mon_e.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid  = '0;
    req_idx    = '0;
    req_valid3 = '0;
    req_idx3   = '0;
    rst_n      = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready",   64'(req_ready), 64'd0);
    check("rst_lut_idx", 64'(lut_idx),   64'd0);
    check("rst_rsp_vld", 64'(rsp_valid), 64'd0);
    check("rst_rmost",   64'(rsp_rmost), 64'd0);
    check("rst_wbr",     64'(rsp_wbr),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single lane 2, idx 0x05 at cycle 10 -> rsp at 13: rmost 15, wbr 0x00500000
    while (cyc < 9) idle(1);
    drive(4'b0100, 32'h0005_0000, 4'b0100, 1'b1, "t1_grant");
    idle(1);
    check("t1_lut_idx", 64'(lut_idx), 64'h05);
    idle(3);

    // rr_ptr = 3: lane 3 alone, winner NREQ-1 wraps pointer to 0
    drive(4'b1000, 32'h4400_0000, 4'b1000, 1'b1, "wrap_grant");

    // All lanes valid from rr_ptr = 0, idx_k = k+1 -> 0,1,2,3,0,1,2,3
    for (int i = 0; i < 8; i++)
      drive(4'b1111, 32'h0403_0201, 4'(4'b0001 << (i % 4)), 1'b1, "all4_grant");

    // Lane 1 alone -> rr_ptr 2; then lanes 1,3 -> 3 first, then 1 -> rr_ptr 2
    drive(4'b0010, 32'h0000_0900, 4'b0010, 1'b1, "l1_grant");
    drive(4'b1010, 32'h0A00_0B00, 4'b1000, 1'b1, "l13_first");
    drive(4'b1010, 32'h0A00_0B00, 4'b0010, 1'b1, "l13_second");
    // rr_ptr must be 2: lanes 0 and 2 valid -> lane 2
    drive(4'b0101, 32'h0006_0007, 4'b0100, 1'b1, "ptr2_grant");

    // Idx 0xFF then 2 idle cycles: address holds, rsp 765 / 0x0FF00000
    drive(4'b0001, 32'h0000_00FF, 4'b0001, 1'b1, "ff_grant");
    idle(1);
    check("ff_hold1", 64'(lut_idx), 64'hFF);
    idle(1);
    check("ff_hold2", 64'(lut_idx), 64'hFF);
    idle(4);
    check("sb_drained1", 64'(sb.size()), 64'd0);

    // Grant lane 1, reset one cycle later: response must vanish
    drive(4'b0010, 32'h0000_7A00, 4'b0010, 1'b0, "rst_grant");
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    #1;
    check("mid_rst_lut_idx", 64'(lut_idx),   64'd0);
    check("mid_rst_rsp_vld", 64'(rsp_valid), 64'd0);
    check("mid_rst_rmost",   64'(rsp_rmost), 64'd0);
    check("mid_rst_wbr",     64'(rsp_wbr),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    // First grant after reset goes to the lowest valid lane
    drive(4'b0101, 32'h0003_0004, 4'b0001, 1'b1, "post_rst_grant");
    idle(5);
    check("sb_drained2", 64'(sb.size()), 64'd0);

    // NREQ = 3: all valid -> 0,1,2,0,1,2 (no phantom lane 3)
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req_valid3 = 3'b111;
      req_idx3   = 24'h03_02_01;
      #1;
      check("n3_grant", 64'(req_ready3), 64'(3'(3'b001 << (i % 3))));
    end
    @(negedge clk);
    req_valid3 = 3'b000;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
